// File: rtl/sqrt_share_ctrl.sv
// sqrt_share_ctrl: shares one fp16 square-root unit among N requesters.
// Round-robin grant, operand held for LAT+1 cycles, IEEE special cases
// resolved locally, results returned in grant order through a tagged FIFO.
module sqrt_share_ctrl #(
    parameter int N     = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [16*N-1:0]   req_data,
    output logic [N-1:0]      req_ready,
    output logic [15:0]       sqrt_in,
    output logic              sqrt_en,
    input  logic [15:0]       sqrt_out,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int CW  = $clog2(LAT + 2);
    localparam int PW  = $clog2(DEPTH);
    localparam int FCW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]      op_reg_q, op_reg_d;
    logic [IDW-1:0]   id_reg_q, id_reg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      sqrt_in_q, sqrt_in_d;
    logic             sqrt_en_q, sqrt_en_d;
    logic [15:0]      fifo_data_q [DEPTH];
    logic [15:0]      fifo_data_d [DEPTH];
    logic [IDW-1:0]   fifo_id_q   [DEPTH];
    logic [IDW-1:0]   fifo_id_d   [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]   fifo_count_q, fifo_count_d;

    logic [15:0]      ops [N];
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             can_grant;
    logic [15:0]      gnt_x;
    logic             is_special;
    logic [15:0]      special_res;
    logic             push;
    logic             pop;
    logic [IDW-1:0]   push_id;
    logic [15:0]      push_data;

    // Unpack the flat operand bus and pick the first valid requester after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ops[i] = req_data[16*i +: 16];
        end
        for (int unsigned k = 1; k <= N; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((32'(rr_ptr_q) + k) % N);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        // Grant only with a free FIFO slot so a later capture can never overflow.
        can_grant = !rst && (state_q == IDLE) && (fifo_count_q < FCW'(DEPTH)) && gnt_found;
        req_ready = can_grant ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
        gnt_x     = ops[gnt_idx];
    end

    // Classify the granted operand: zero, negative, Inf/NaN bypass the unit.
    always_comb begin
        is_special  = 1'b1;
        special_res = gnt_x;
        if (gnt_x[14:0] == '0) begin
            special_res = gnt_x;
        end else if (gnt_x[15]) begin
            special_res = 16'h7E00;
        end else if (gnt_x[14:10] == 5'h1F) begin
            special_res = gnt_x;
        end else begin
            is_special = 1'b0;
        end
    end

    // Next-state logic for the grant/hold FSM and the result FIFO.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_reg_d     = op_reg_q;
        id_reg_d     = id_reg_q;
        cnt_d        = cnt_q;
        sqrt_in_d    = sqrt_in_q;
        sqrt_en_d    = sqrt_en_q;
        fifo_data_d  = fifo_data_q;
        fifo_id_d    = fifo_id_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        push         = 1'b0;
        push_id      = '0;
        push_data    = '0;
        pop          = rsp_ready && (fifo_count_q != '0);

        unique case (state_q)
            IDLE: begin
                if (can_grant) begin
                    rr_ptr_d = gnt_idx;
                    if (is_special) begin
                        push      = 1'b1;
                        push_id   = gnt_idx;
                        push_data = special_res;
                    end else begin
                        op_reg_d  = gnt_x;
                        id_reg_d  = gnt_idx;
                        cnt_d     = CW'(LAT);
                        state_d   = HOLD;
                        sqrt_en_d = 1'b1;
                        sqrt_in_d = gnt_x;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    push      = 1'b1;
                    push_id   = id_reg_q;
                    push_data = sqrt_out;
                    state_d   = IDLE;
                    sqrt_en_d = 1'b0;
                    sqrt_in_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_id_d[wr_ptr_q]   = push_id;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + FCW'(1);
            2'b01:   fifo_count_d = fifo_count_q - FCW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State, hold and FIFO registers; reset drops any in-flight operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDW'(N - 1);
            op_reg_q     <= '0;
            id_reg_q     <= '0;
            cnt_q        <= '0;
            sqrt_in_q    <= '0;
            sqrt_en_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_id_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_reg_q     <= op_reg_d;
            id_reg_q     <= id_reg_d;
            cnt_q        <= cnt_d;
            sqrt_in_q    <= sqrt_in_d;
            sqrt_en_q    <= sqrt_en_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            fifo_data_q  <= fifo_data_d;
            fifo_id_q    <= fifo_id_d;
        end
    end

    assign sqrt_in   = sqrt_in_q;
    assign sqrt_en   = sqrt_en_q;
    assign rsp_valid = (fifo_count_q != '0);
    assign rsp_id    = fifo_id_q[rd_ptr_q];
    assign rsp_data  = fifo_data_q[rd_ptr_q];
    assign busy      = (state_q != IDLE) || (fifo_count_q != '0);

endmodule
